// File: rtl/rr_arb_pkg.sv
// Shared definitions for the 16-requester round-robin arbiter: sizes, FSM
// state encoding and the post-reset value of the last-granted pointer.
package rr_arb_pkg;

    localparam int NREQ = 16;
    localparam int IDXW = 4;

    // Client 15 counts as last-granted after reset, so client 0 is searched first
    localparam logic [IDXW-1:0] LAST_RST = 4'd15;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arb16_if.sv
// Request/grant bundle between the 16 clients and the arbiter.
// Optional lock line exists only when ARB_LOCK_EN is defined.
interface rr_arb16_if;
    import rr_arb_pkg::*;

    logic            e;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [IDXW-1:0] gnt_idx;
    logic            gnt_vld;
`ifdef ARB_LOCK_EN
    logic            lock;
`endif

    // Client side: drives requests, observes grants
    modport master (
        output e,
        output req,
`ifdef ARB_LOCK_EN
        output lock,
`endif
        input  gnt,
        input  gnt_idx,
        input  gnt_vld
    );

    // Arbiter side
    modport slave (
        input  e,
        input  req,
`ifdef ARB_LOCK_EN
        input  lock,
`endif
        output gnt,
        output gnt_idx,
        output gnt_vld
    );

endinterface

// File: rtl/rr_pick16.sv
// Combinational round-robin picker: first set request bit strictly after
// 'last', searching circularly upward; 'last' itself is searched last.
module rr_pick16
    import rr_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last,
    output logic            hit,
    output logic [IDXW-1:0] idx
);

    logic [IDXW-1:0] cand_s;

    assign hit = |req;

    // Scan from the farthest offset down so the nearest requester wins
    always_comb begin
        idx    = {IDXW{1'b0}};
        cand_s = {IDXW{1'b0}};
        for (int i = NREQ; i >= 1; i--) begin
            cand_s = last + IDXW'(i);
            idx    = req[cand_s] ? cand_s : idx;
        end
    end

endmodule

// File: rtl/rr_arb16.sv
// 16-requester round-robin arbiter with bounded hold time (MAX_HOLD, 0 = no limit).
// Define ARB_LOCK_EN to add a lock input that suppresses the hold-time release.
module rr_arb16
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNTW     = 8
)(
    input  logic        clk,
    input  logic        rst,
    rr_arb16_if.slave   bus
);

    localparam bit              TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [CNTW-1:0] HOLD_LAST  = (MAX_HOLD == 0) ? {CNTW{1'b0}}
                                                             : CNTW'(MAX_HOLD - 1);

    state_t          state_r;
    logic [NREQ-1:0] gnt_r;
    logic [IDXW-1:0] gnt_idx_r;
    logic            gnt_vld_r;
    logic [IDXW-1:0] last_r;
    logic [CNTW-1:0] hold_cnt_r;

    logic            pick_hit_s;
    logic [IDXW-1:0] pick_idx_s;
    logic            lock_s;
    logic            timeout_s;
    logic            release_s;

    rr_pick16 u_pick (
        .req  (bus.req),
        .last (last_r),
        .hit  (pick_hit_s),
        .idx  (pick_idx_s)
    );

`ifdef ARB_LOCK_EN
    assign lock_s = bus.lock;
`else
    assign lock_s = 1'b0;
`endif

    // A grant ends when its owner drops the request or its hold budget is spent
    assign timeout_s = TIMEOUT_EN && !lock_s && (hold_cnt_r == HOLD_LAST);
    assign release_s = !bus.req[gnt_idx_r] || timeout_s;

    // Arbitration FSM with registered grant outputs and hold counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            gnt_r      <= {NREQ{1'b0}};
            gnt_idx_r  <= {IDXW{1'b0}};
            gnt_vld_r  <= 1'b0;
            last_r     <= LAST_RST;
            hold_cnt_r <= {CNTW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.e && pick_hit_s) begin
                        state_r    <= ST_BUSY;
                        gnt_r      <= NREQ'(1) << pick_idx_s;
                        gnt_idx_r  <= pick_idx_s;
                        gnt_vld_r  <= 1'b1;
                        last_r     <= pick_idx_s;
                        hold_cnt_r <= {CNTW{1'b0}};
                    end else begin
                        gnt_r      <= {NREQ{1'b0}};
                        gnt_idx_r  <= {IDXW{1'b0}};
                        gnt_vld_r  <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    // Release always passes through IDLE, giving a one-cycle gap
                    if (release_s) begin
                        state_r   <= ST_IDLE;
                        gnt_r     <= {NREQ{1'b0}};
                        gnt_idx_r <= {IDXW{1'b0}};
                        gnt_vld_r <= 1'b0;
                    end else if (hold_cnt_r != {CNTW{1'b1}}) begin
                        hold_cnt_r <= hold_cnt_r + CNTW'(1);
                    end else begin
                        hold_cnt_r <= hold_cnt_r;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    gnt_r     <= {NREQ{1'b0}};
                    gnt_idx_r <= {IDXW{1'b0}};
                    gnt_vld_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_r;
    assign bus.gnt_idx = gnt_idx_r;
    assign bus.gnt_vld = gnt_vld_r;

endmodule

// File: tb/tb_rr_arb16.sv
// Scoreboard bench for rr_arb16 (MAX_HOLD=4): stimulus pushes expected grants
// (client, hold length); a negedge monitor pops and checks each grant it sees.
module tb_rr_arb16;

    typedef struct {
        int idx;
        int len;   // 0: grant cut short by reset, length not checked
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t q[$];

    rr_arb16_if bus();

    rr_arb16 #(.MAX_HOLD(4), .CNTW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_gnt(input int idx, input int len);
        exp_t x;
        x.idx = idx;
        x.len = len;
        q.push_back(x);
    endtask

    // Monitor: pops one expectation per grant and measures its length
    initial begin
        logic prev_vld;
        int   cur_len;
        exp_t cur;
        prev_vld = 1'b0;
        cur_len  = 0;
        cur.idx  = 0;
        cur.len  = 0;
        forever begin
            @(negedge clk);
            chk("gnt_vs_idx", int'(bus.gnt),
                bus.gnt_vld ? (32'd1 << bus.gnt_idx) : 32'd0);
            if (bus.gnt_vld) begin
                if (!prev_vld) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_grant: got idx %0d expected none at %0t",
                                 bus.gnt_idx, $time);
                        cur.len = 0;
                    end else begin
                        cur = q.pop_front();
                        chk("gnt_idx", int'(bus.gnt_idx), cur.idx);
                        chk("gnt_onehot", int'(bus.gnt), 32'd1 << cur.idx);
                    end
                    cur_len = 1;
                end else begin
                    cur_len++;
                end
            end else if (prev_vld && cur.len != 0) begin
                chk("hold_len", cur_len, cur.len);
            end
            prev_vld = bus.gnt_vld;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] v;
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        bus.e   = 1'b1;
        bus.req = 16'h0000;
`ifdef ARB_LOCK_EN
        bus.lock = 1'b0;
`endif
        @(negedge clk);
        chk("rst_gnt", int'(bus.gnt), 0);
        chk("rst_idx", int'(bus.gnt_idx), 0);
        chk("rst_vld", int'(bus.gnt_vld), 0);
        rst = 1'b0;

        // Single requester, one-cycle latency, release on req drop
        bus.req = 16'h0001;
        expect_gnt(0, 1);
        @(negedge clk);
        bus.req = 16'h0000;
        repeat (3) @(negedge clk);

        // Two persistent requesters alternate under the hold timeout
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.req = 16'h8001;
        expect_gnt(0, 4);
        expect_gnt(15, 4);
        expect_gnt(0, 4);
        expect_gnt(15, 4);
        repeat (20) @(negedge clk);
        bus.req = 16'h0000;
        repeat (2) @(negedge clk);

        // All requesting, each drops two cycles into its grant: strict rotation
        for (int k = 0; k < 17; k++) begin
            expect_gnt(k % 16, 2);
            bus.req = 16'hFFFF;
            repeat (2) @(negedge clk);
            v = 16'hFFFF;
            v[k % 16] = 1'b0;
            bus.req = v;
            @(negedge clk);
        end
        bus.req = 16'h0000;
        repeat (2) @(negedge clk);

        // Enable gating: blocks new grants only
        bus.e   = 1'b0;
        bus.req = 16'h0010;
        repeat (3) @(negedge clk);
        chk("e0_no_grant", int'(bus.gnt_vld), 0);
        bus.e = 1'b1;
        expect_gnt(4, 3);
        @(negedge clk);
        bus.e = 1'b0;
        repeat (2) @(negedge clk);
        bus.req = 16'h0000;
        repeat (2) @(negedge clk);
        bus.e = 1'b1;

        // Asynchronous reset mid-grant, then arbitration restarts at client 0
        bus.req = 16'h0080;
        expect_gnt(7, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_gnt", int'(bus.gnt), 0);
        chk("async_rst_vld", int'(bus.gnt_vld), 0);
        chk("async_rst_idx", int'(bus.gnt_idx), 0);
        bus.req = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
        bus.req = 16'h0081;
        expect_gnt(0, 2);
        repeat (2) @(negedge clk);
        bus.req = 16'h0080;
        expect_gnt(7, 2);
        repeat (3) @(negedge clk);
        bus.req = 16'h0000;
        repeat (2) @(negedge clk);

`ifdef ARB_LOCK_EN
        // Lock holds the grant past the timeout; without lock the timeout applies
        bus.lock = 1'b1;
        bus.req  = 16'h0008;
        expect_gnt(3, 10);
        repeat (10) @(negedge clk);
        bus.req = 16'h0000;
        @(negedge clk);
        bus.lock = 1'b0;
        bus.req  = 16'h0008;
        expect_gnt(3, 4);
        repeat (5) @(negedge clk);
        bus.req = 16'h0000;
        repeat (2) @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arb16.md
Name: rr_arb16

Overview:
- 16-requester round-robin arbiter for a shared resource.
- Emits a one-hot grant vector plus the 4-bit grant index and a valid flag.
- Sits in front of the 16-way select/enable fabric, so that at most one of 16 clients owns the resource at a time.
- Hold time per grant is bounded by a programmable timeout.

Parameters:
- MAX_HOLD, 16, maximum cycles a grant may be held (1..255); 0 disables the timeout.
- CNTW, 8, hold counter width; MAX_HOLD must fit in CNTW bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- e  input  1  arbiter enable; 0 blocks new grants, an existing grant continues
- req  input  16  request lines, bit k = client k, level-sensitive
- gnt  output  16  one-hot grant, registered
- gnt_idx  output  4  binary index of the granted client, registered
- gnt_vld  output  1  1 while any grant is active
- lock  input  1  present only with ARB_LOCK_EN; see Optional Feature

Behaviour:
- One clock; reset is asynchronous and active-high; all state is cleared immediately on rst=1, independent of clk.
- Reset values:
  - state=IDLE
  - gnt=16'h0000, gnt_idx=4'd0, gnt_vld=0
  - last=4'd15, so client 0 has top priority after reset
  - hold_cnt=0
- States are IDLE and BUSY.
- IDLE:
  - If e=1 and |req=1: select the first k with req[k]=1, searching circularly from last+1 (mod 16) upward.
  - Register gnt=1<<k, gnt_idx=k, gnt_vld=1, last=k, hold_cnt=0, and go to BUSY.
  - Latency: req rising at edge n gives gnt visible after edge n+1, i.e. one cycle.
  - Otherwise stay in IDLE with outputs at zero.
- BUSY:
  - hold_cnt increments each cycle and saturates at 2^CNTW-1.
  - Release occurs when req[gnt_idx]=0, or when MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1.
  - On release, the next edge clears gnt/gnt_vld/gnt_idx and returns to IDLE.
  - gnt_idx is cleared to 0 on release, not held.
- Turnaround: at least one cycle with gnt_vld=0 between any two grants, including a re-grant to the same client.
- Fairness: last updates only on a grant. A timed-out client still requesting is searched last, so any other requester wins the next arbitration. If it is the sole requester, it is re-granted after the one-cycle gap.
- e=0 while BUSY: no effect on the current grant. e=0 while IDLE: no grant; last is unchanged.
- req changes on non-granted bits during BUSY are ignored until IDLE.
- Invariants: gnt is always zero or one-hot. gnt==(gnt_vld ? 1<<gnt_idx : 0).
- Reset mid-BUSY: grant drops asynchronously and arbitration restarts from client 0.

Optional Feature:
- Macro ARB_LOCK_EN.
- When defined:
  - The lock input exists.
  - While BUSY and lock=1, the timeout release is suppressed and hold_cnt keeps saturating.
  - Release then happens only on req[gnt_idx]=0.
  - lock is ignored in IDLE.
- When undefined:
  - No lock port.
  - Timeout always applies per MAX_HOLD.

Decomposition:
- Shared package/header (rr_arb_pkg):
  - state encodings ST_IDLE=1'b0, ST_BUSY=1'b1
  - NREQ=16, IDXW=4
  - reset value of last (4'd15)
- Sub-module rr_pick16:
  - Purely combinational.
  - Inputs: req[15:0], last[3:0].
  - Outputs: hit, idx[3:0] of the first set bit after last, circularly.
- Top: FSM, hold counter, output registers, and 4-to-16 one-hot expansion of idx.

Test Plan:
- Reset then req=16'h0001 -> after 1 cycle gnt=16'h0001, gnt_idx=0, gnt_vld=1; drop req -> gnt_vld=0 next edge.
- After reset, req=16'h8001 held constant, MAX_HOLD=4 -> grant order 0,15,0,15…, each gnt_vld high exactly 4 cycles, 1-cycle gaps.
- req=16'hFFFF, each client drops req 2 cycles after its grant -> grants 0,1,2…15,0 in strict rotation; gnt always one-hot.
- e=0 with req=16'h0010 -> no grant. e=1 -> gnt=16'h0010 next cycle. e=0 during BUSY -> grant persists until req[4] drops.
- Assert rst mid-grant (gnt_idx=7) asynchronously -> gnt=0, gnt_vld=0 before next clk. With req=16'h0081 after release -> client 0 granted first.
- ARB_LOCK_EN defined, MAX_HOLD=4, lock=1, req[3] held 10 cycles -> gnt_vld high 10 cycles. lock=0 -> timeout after 4 cycles.
